// File: rtl/id_ex_stage_reg_pkg.sv
// Shared constants for the ID/EX pipeline register:
// NZCV bit positions, ALU commands, condition codes, widths.
package id_ex_stage_reg_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int IMM_W_DEF  = 24;
    localparam int SHOP_W_DEF = 12;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef enum logic [3:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_MVN = 4'b1001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_LDR = 4'b1010,
        EXE_STR = 4'b1011
    } exe_cmd_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE
    } cond_e;

endpackage

// File: rtl/id_ex_stage_reg_status_reg.sv
// Architectural NZCV status register with a load enable.
// Reset clears all flags; no bypass from d to q.
module status_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] nzcv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_q <= 4'b0000;
        end else if (en) begin
            nzcv_q <= d;
        end
    end

    assign q = nzcv_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EXE pipeline register. Squashes condition-failed instructions
// and owns the NZCV status register that feeds the condition checker.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMM_W  = IMM_W_DEF,
    parameter int SHOP_W = SHOP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic              bubble,
    input  logic              id_valid,
    input  logic              cond_pass,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_val_rn,
    input  logic [DATA_W-1:0] id_val_rm,
    input  logic [3:0]        id_exe_cmd,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic              id_b,
    input  logic              id_s,
    input  logic              id_imm,
    input  logic [SHOP_W-1:0] id_shop,
    input  logic [IMM_W-1:0]  id_simm,
    input  logic [3:0]        id_dest,
    input  logic [3:0]        ex_status_in,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_val_rn,
    output logic [DATA_W-1:0] ex_val_rm,
    output logic [3:0]        ex_exe_cmd,
    output logic              ex_wb_en,
    output logic              ex_mem_r_en,
    output logic              ex_mem_w_en,
    output logic              ex_b,
    output logic              ex_s,
    output logic              ex_imm,
    output logic [SHOP_W-1:0] ex_shop,
    output logic [IMM_W-1:0]  ex_simm,
    output logic [3:0]        ex_dest,
    output logic [3:0]        flags_nzcv
);

    logic              valid_q, valid_d;
    logic              wb_q, wb_d;
    logic              mr_q, mr_d;
    logic              mw_q, mw_d;
    logic              b_q, b_d;
    logic              s_q, s_d;
    logic              imm_q, imm_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] rn_q, rn_d;
    logic [DATA_W-1:0] rm_q, rm_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [SHOP_W-1:0] shop_q, shop_d;
    logic [IMM_W-1:0]  simm_q, simm_d;
    logic [3:0]        dest_q, dest_d;

    logic live;
    logic upd;

    assign live = id_valid & cond_pass;

    // Priority: hold > flush/bubble > load.
    always_comb begin
        valid_d = valid_q;
        wb_d    = wb_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        b_d     = b_q;
        s_d     = s_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        cmd_d   = cmd_q;
        shop_d  = shop_q;
        simm_d  = simm_q;
        dest_d  = dest_q;
        if (hold) begin
            valid_d = valid_q;
        end else if (flush || bubble) begin
            valid_d = 1'b0;
            wb_d    = 1'b0;
            mr_d    = 1'b0;
            mw_d    = 1'b0;
            b_d     = 1'b0;
            s_d     = 1'b0;
            imm_d   = 1'b0;
            pc_d    = '0;
            rn_d    = '0;
            rm_d    = '0;
            cmd_d   = '0;
            shop_d  = '0;
            simm_d  = '0;
            dest_d  = '0;
        end else begin
            valid_d = live;
            wb_d    = id_wb_en & live;
            mr_d    = id_mem_r_en & live;
            mw_d    = id_mem_w_en & live;
            b_d     = id_b & live;
            s_d     = id_s & live;
            imm_d   = id_imm;
            pc_d    = id_pc;
            rn_d    = id_val_rn;
            rm_d    = id_val_rm;
            cmd_d   = id_exe_cmd;
            shop_d  = id_shop;
            simm_d  = id_simm;
            dest_d  = id_dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            wb_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            b_q     <= 1'b0;
            s_q     <= 1'b0;
            imm_q   <= 1'b0;
            pc_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            cmd_q   <= '0;
            shop_q  <= '0;
            simm_q  <= '0;
            dest_q  <= '0;
        end else begin
            valid_q <= valid_d;
            wb_q    <= wb_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            b_q     <= b_d;
            s_q     <= s_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            cmd_q   <= cmd_d;
            shop_q  <= shop_d;
            simm_q  <= simm_d;
            dest_q  <= dest_d;
        end
    end

    // Flags belong to the instruction leaving EXE, so flush/bubble do not gate them.
    assign upd = valid_q & s_q & ~hold;

    status_reg u_status (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (upd),
        .d     (ex_status_in),
        .q     (flags_nzcv)
    );

    assign ex_valid    = valid_q;
    assign ex_wb_en    = wb_q;
    assign ex_mem_r_en = mr_q;
    assign ex_mem_w_en = mw_q;
    assign ex_b        = b_q;
    assign ex_s        = s_q;
    assign ex_imm      = imm_q;
    assign ex_pc       = pc_q;
    assign ex_val_rn   = rn_q;
    assign ex_val_rm   = rm_q;
    assign ex_exe_cmd  = cmd_q;
    assign ex_shop     = shop_q;
    assign ex_simm     = simm_q;
    assign ex_dest     = dest_q;

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between the ID and EXE stages. Captures the decoded instruction and operands each cycle.
- Consumes the condition-check pass bit and squashes side effects of instructions whose condition fails.
- Owns the architectural NZCV status register. Its flag outputs feed the ID-stage condition checker, closing the ID→EXE→flags loop.

Parameters:
- DATA_W, 32, width of the PC and operand values
- IMM_W, 24, width of the signed branch immediate
- SHOP_W, 12, width of the shifter operand

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  global memory-wait freeze; the whole stage holds
- flush  in  1  branch-taken squash from EXE
- bubble  in  1  hazard-unit stall; inject a NOP into EXE
- id_valid  in  1  ID holds a real instruction
- cond_pass  in  1  condition-check result for the ID instruction
- id_pc  in  DATA_W  PC+4 of the ID instruction
- id_val_rn, id_val_rm  in  DATA_W each  register-file operands
- id_exe_cmd  in  4  ALU command
- id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm  in  1 each  decoded control bits
- id_shop  in  SHOP_W  shifter operand
- id_simm  in  IMM_W  signed 24-bit branch offset
- id_dest  in  4  destination register index
- ex_status_in  in  4  {N,Z,C,V} produced by the EXE ALU
- ex_valid  out  1  EXE holds a live instruction
- ex_pc, ex_val_rn, ex_val_rm, ex_exe_cmd, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm, ex_shop, ex_simm, ex_dest  out  same widths as their inputs  registered copies
- flags_nzcv  out  4  current status register {N,Z,C,V}, to the condition checker

Behaviour:
- Async reset (rst_n=0):
  - All outputs are 0 immediately, including flags_nzcv=4'b0000 and ex_valid=0.
  - Release is synchronous to the next clk edge.
- Per rising edge, the priority is hold > flush > bubble > load:
  - hold=1: every register keeps its value, including flags. flush and bubble are ignored; the upstream stage keeps them asserted until hold drops.
  - flush=1: ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b and ex_s are cleared, and all data fields are cleared to 0.
  - bubble=1: same effect as flush.
  - load:
    - Define live = id_valid & cond_pass.
    - ex_valid <= live.
    - Each control bit (wb_en, mem_r_en, mem_w_en, b, s) <= id_x & live.
    - Data fields (pc, vals, cmd, imm, shop, simm, dest) load unconditionally.
- A condition-failed instruction therefore still advances (PC and data are visible for debug) but has no architectural effect.
- Status register (sub-module):
  - Update enable is upd = ex_valid & ex_s & ~hold. On a clock edge with upd=1, flags_nzcv <= ex_status_in.
  - The update is visible one cycle after the flag-setting instruction sits in EXE. There is no combinational bypass to flags_nzcv.
  - A dependent conditional instruction in ID during that same cycle sees the old flags. The hazard unit must bubble it; this block does not detect that case.
- Flush or bubble in the same cycle as upd=1: the status update still happens, because it belongs to the instruction leaving EXE, not the one entering.
- Reset asserted mid-operation: everything clears asynchronously. No partial state survives.
- Latency is 1 cycle ID→EXE for all fields. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package:
  - NZCV bit-index constants (N=3, Z=2, C=1, V=0)
  - EXE_CMD 4-bit encodings
  - Cond-code encodings EQ..AL
  - DATA_W/IMM_W/SHOP_W defaults
- One natural sub-module, status_reg:
  - Ports: clk, rst_n, en, d[3:0], q[3:0].
  - Instantiated with en=upd.
- The remainder is flat register logic.

Test Plan:
- rst_n low mid-stream with ex_wb_en=1 and flags=4'b1010 → outputs 0 and flags 4'b0000 before the next clk edge; first load after release is captured normally.
- Load with id_valid=1, cond_pass=0, id_wb_en=1, id_mem_w_en=1, id_pc=32'h0000_0010 → next cycle ex_valid=0, ex_wb_en=0, ex_mem_w_en=0, ex_pc=32'h10.
- ex_s=1, ex_valid=1, ex_status_in=4'b0100, hold=0 → flags_nzcv=4'b0100 one cycle later; with hold=1 for 3 cycles, flags unchanged until the cycle after hold drops.
- flush=1 and bubble=1 together with id_valid=1, cond_pass=1, id_b=1 → ex_b=0, ex_valid=0, all data 0; with hold=1 in the same cycle → all outputs unchanged.
- Back-to-back flag-setting instructions (status 4'b1000, then 4'b0001) → flags 4'b1000 at cycle n+1 and 4'b0001 at cycle n+2, with no skipped update.
- Flush in the cycle a flag-setting instruction is in EXE (ex_status_in=4'b0010) → flags_nzcv=4'b0010 next cycle and ex_valid=0.
